// File: rtl/fir_onset_detector.sv
// Sliding-window magnitude energy over the filtered FIR stream. Onsets are detected with
// threshold hysteresis and a holdoff period, and each onset latches a sample-count timestamp.
module fir_onset_detector #(
  parameter int DW         = 23,
  parameter int WIN_LOG2   = 4,
  parameter int TS_W       = 24,
  parameter int HOLDOFF    = 400,
  parameter int AUTO_REARM = 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_n,
  input  logic signed [DW-1:0]     sample_in,
  input  logic                     sample_valid,
  input  logic                     arm,
  input  logic [DW+WIN_LOG2-1:0]   thresh_on,
  input  logic [DW+WIN_LOG2-1:0]   thresh_off,
  output logic [DW+WIN_LOG2-1:0]   energy_out,
  output logic                     onset,
  output logic [TS_W-1:0]          onset_ts,
  output logic                     ts_valid,
  output logic [1:0]               state_out
);

  localparam int WIN = 1 << WIN_LOG2;
  localparam int EW  = DW + WIN_LOG2;
  localparam int HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIG  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  logic [DW-2:0]       r_ring [WIN];
  logic [WIN_LOG2-1:0] r_wptr;
  logic [EW-1:0]       r_sum;
  logic [TS_W-1:0]     r_tsCnt;
  logic [TS_W-1:0]     r_tsE;
  logic                r_upd;
  logic [HW-1:0]       r_hold;
  logic [TS_W-1:0]     r_onsetTs;
  logic                r_tsValid;
  state_t              r_state;
  state_t              w_stateNext;
  logic                w_capture;
  logic [DW-2:0]       w_mag;
  logic                w_isMin;
  logic [EW-1:0]       w_sumNext;

  // The most negative input has no positive counterpart, so it saturates to all ones.
  always_comb begin
    w_isMin = sample_in[DW-1] && (sample_in[DW-2:0] == '0);
    if (w_isMin) begin
      w_mag = '1;
    end else if (sample_in[DW-1]) begin
      w_mag = ~sample_in[DW-2:0] + (DW-1)'(1);
    end else begin
      w_mag = sample_in[DW-2:0];
    end
    w_sumNext = r_sum + EW'(w_mag) - EW'(r_ring[r_wptr]);
  end

  always_ff @(posedge clk_clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < WIN; i++) begin
        r_ring[i] <= '0;
      end
      r_wptr  <= '0;
      r_sum   <= '0;
      r_tsCnt <= '0;
      r_tsE   <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= sample_valid;
      if (sample_valid) begin
        r_ring[r_wptr] <= w_mag;
        r_wptr         <= r_wptr + WIN_LOG2'(1);
        r_sum          <= w_sumNext;
        r_tsE          <= r_tsCnt;
        r_tsCnt        <= r_tsCnt + TS_W'(1);
      end
    end
  end

  // Energy is judged one cycle after it settles, on the delayed strobe r_upd.
  always_comb begin
    w_stateNext = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_stateNext = S_ARMED;
        end
      end
      S_ARMED: begin
        if (r_upd && (r_sum >= thresh_on)) begin
          w_stateNext = S_TRIG;
          w_capture   = 1'b1;
        end
      end
      S_TRIG: begin
        w_stateNext = S_HOLD;
      end
      S_HOLD: begin
        if ((r_hold == '0) && r_upd && (r_sum < thresh_off)) begin
          w_stateNext = (AUTO_REARM != 0) ? S_ARMED : S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_n) begin
    if (reset_n) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_onsetTs <= '0;
      r_tsValid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_capture) begin
        r_onsetTs <= r_tsE;
        r_tsValid <= 1'b1;
      end
      if (r_state == S_TRIG) begin
        r_hold <= HW'(HOLDOFF);
      end else if ((r_state == S_HOLD) && sample_valid && (r_hold != '0)) begin
        r_hold <= r_hold - HW'(1);
      end
    end
  end

  assign energy_out = r_sum;
  assign onset      = (r_state == S_TRIG);
  assign onset_ts   = r_onsetTs;
  assign ts_valid   = r_tsValid;
  assign state_out  = r_state;

endmodule

// File: tb/tb_fir_onset_detector.sv
// Directed bench for fir_onset_detector: stimulus pushes expected energies and onset
// timestamps into queues, and negedge monitors pop and compare them as the DUTs respond.
module tb_fir_onset_detector;

  localparam int DW   = 23;
  localparam int TS_W = 24;
  localparam int EW   = 27;

  logic                 clk = 1'b0;
  logic                 rst1;
  logic                 rst2;
  logic signed [DW-1:0] sampleIn;
  logic                 sv1;
  logic                 sv2;
  logic                 arm1;
  logic                 arm2;
  logic [EW-1:0]        threshOn;
  logic [EW-1:0]        threshOff;

  logic [EW-1:0]        energy1;
  logic                 onset1;
  logic [TS_W-1:0]      ts1;
  logic                 tsValid1;
  logic [1:0]           state1;
  logic [EW-1:0]        energy2;
  logic                 onset2;
  logic [TS_W-1:0]      ts2;
  logic                 tsValid2;
  logic [1:0]           state2;

  int nCompared = 0;
  int nFailed   = 0;

  int energyQ[$];
  int onsetQ[$];
  int onset2Q[$];
  int magHist[$];
  int modelTs[2];

  bit sv1D1 = 1'b0;
  bit sv1D2 = 1'b0;
  bit sv2D1 = 1'b0;
  bit sv2D2 = 1'b0;

  always #5 clk = ~clk;

  fir_onset_detector #(.HOLDOFF(400), .AUTO_REARM(1)) dut1 (
    .clk_clk(clk), .reset_n(rst1), .sample_in(sampleIn), .sample_valid(sv1), .arm(arm1),
    .thresh_on(threshOn), .thresh_off(threshOff), .energy_out(energy1), .onset(onset1),
    .onset_ts(ts1), .ts_valid(tsValid1), .state_out(state1)
  );

  // Short holdoff, no auto re-arm: exercises the return-to-IDLE path.
  fir_onset_detector #(.HOLDOFF(8), .AUTO_REARM(0)) dut2 (
    .clk_clk(clk), .reset_n(rst2), .sample_in(sampleIn), .sample_valid(sv2), .arm(arm2),
    .thresh_on(threshOn), .thresh_off(threshOff), .energy_out(energy2), .onset(onset2),
    .onset_ts(ts2), .ts_valid(tsValid2), .state_out(state2)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nCompared++;
    if (actual !== expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int magOf(input int v);
    if (v == -4194304) return 4194303;
    return (v < 0) ? -v : v;
  endfunction

  // Drives one sample at posedge+2 and pushes the expected response for the monitors.
  task automatic applyStimulus(input int which, input int v, input bit expOnset, input int gap);
    int sum;
    if (which == 0) begin
      magHist.push_back(magOf(v));
      if (magHist.size() > 16) void'(magHist.pop_front());
      sum = 0;
      foreach (magHist[k]) sum += magHist[k];
      energyQ.push_back(sum);
      if (expOnset) onsetQ.push_back(modelTs[0]);
    end else if (expOnset) begin
      onset2Q.push_back(modelTs[1]);
    end
    modelTs[which]++;
    sampleIn = v[DW-1:0];
    if (which == 0) sv1 = 1'b1; else sv2 = 1'b1;
    @(posedge clk); #2;
    sv1 = 1'b0;
    sv2 = 1'b0;
    repeat (gap) begin @(posedge clk); #2; end
  endtask

  task automatic pulseArm(input int which);
    if (which == 0) arm1 = 1'b1; else arm2 = 1'b1;
    @(posedge clk); #2;
    arm1 = 1'b0;
    arm2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  always @(negedge clk) begin
    if (sv1D1 && (energyQ.size() != 0)) begin
      checkOutput("energy_out", energy1, energyQ.pop_front());
    end
    if (onset1) begin
      if (onsetQ.size() == 0) begin
        checkOutput("onset_unexpected", onset1, 0);
      end else begin
        checkOutput("onset_ts", ts1, onsetQ.pop_front());
        checkOutput("onset_ts_valid", tsValid1, 1);
        checkOutput("onset_state", state1, 2);
        checkOutput("onset_latency", sv1D2, 1);
      end
    end
    sv1D2 <= sv1D1;
    sv1D1 <= sv1;
  end

  always @(negedge clk) begin
    if (onset2) begin
      if (onset2Q.size() == 0) begin
        checkOutput("onset2_unexpected", onset2, 0);
      end else begin
        checkOutput("onset2_ts", ts2, onset2Q.pop_front());
        checkOutput("onset2_ts_valid", tsValid2, 1);
        checkOutput("onset2_state", state2, 2);
        checkOutput("onset2_latency", sv2D2, 1);
      end
    end
    sv2D2 <= sv2D1;
    sv2D1 <= sv2;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    sv1 = 1'b0; sv2 = 1'b0; arm1 = 1'b0; arm2 = 1'b0;
    sampleIn = '0;
    threshOn = 27'd10000; threshOff = 27'd500;
    modelTs[0] = 0; modelTs[1] = 0;
    repeat (3) @(posedge clk);
    #2;
    rst1 = 1'b0; rst2 = 1'b0;
    idle(1);

    checkOutput("reset_energy", energy1, 0);
    checkOutput("reset_onset", onset1, 0);
    checkOutput("reset_onset_ts", ts1, 0);
    checkOutput("reset_ts_valid", tsValid1, 0);
    checkOutput("reset_state", state1, 0);
    checkOutput("reset_state2", state2, 0);

    // Burst of +1000: onset on the 10th sample (energy 10000, timestamp 9).
    pulseArm(0);
    checkOutput("armed", state1, 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1000, i == 9, 3);
    checkOutput("burst_energy", energy1, 16000);
    checkOutput("burst_state", state1, 3);
    checkOutput("burst_ts", ts1, 9);
    checkOutput("burst_ts_valid", tsValid1, 1);

    // 6 post-onset samples already counted; 394 zeros finish the 400-sample holdoff.
    for (int i = 0; i < 393; i++) applyStimulus(0, 0, 1'b0, 3);
    checkOutput("holdoff_pending", state1, 3);
    applyStimulus(0, 0, 1'b0, 3);
    checkOutput("holdoff_rearmed", state1, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1'b0, 3);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1000, i == 9, 3);
    checkOutput("second_onset_ts", ts1, 425);
    checkOutput("second_onset_state", state1, 3);

    // Energy held above thresh_off long past counter expiry, then decays.
    threshOff = 27'd5000;
    for (int i = 0; i < 600; i++) applyStimulus(0, 1000, 1'b0, 0);
    idle(3);
    checkOutput("held_high_state", state1, 3);
    for (int i = 0; i < 11; i++) applyStimulus(0, 0, 1'b0, 3);
    checkOutput("at_thresh_off_state", state1, 3);
    applyStimulus(0, 0, 1'b0, 3);
    checkOutput("below_thresh_off_state", state1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1'b0, 3);
    checkOutput("drained_energy", energy1, 0);

    // Mid-burst asynchronous reset clears everything immediately.
    threshOn = 27'd100000;
    pulseArm(0);
    checkOutput("arm_in_armed", state1, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, (i % 2) ? 1000 : -1000, 1'b0, 0);
    idle(3);
    checkOutput("mid_burst_energy", energy1, 8000);
    #1;
    rst1 = 1'b1;
    #1;
    checkOutput("async_reset_energy", energy1, 0);
    checkOutput("async_reset_state", state1, 0);
    checkOutput("async_reset_ts_valid", tsValid1, 0);
    checkOutput("async_reset_onset_ts", ts1, 0);
    @(posedge clk); #2;
    rst1 = 1'b0;
    magHist.delete();
    modelTs[0] = 0;

    // Mixed-sign window gives the same energies; timestamps restart at 0.
    threshOn = 27'd10000;
    pulseArm(0);
    for (int i = 0; i < 16; i++) applyStimulus(0, (i % 2) ? 1000 : -1000, i == 9, 3);
    checkOutput("mixed_energy", energy1, 16000);
    checkOutput("mixed_onset_ts", ts1, 9);
    applyStimulus(0, -4194304, 1'b0, 3);
    checkOutput("min_input_energy", energy1, 4209303);

    // AUTO_REARM=0 instance: returns to IDLE and needs a fresh arm pulse.
    threshOff = 27'd500;
    pulseArm(1);
    checkOutput("dut2_armed", state2, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1000, i == 9, 3);
    checkOutput("dut2_holdoff", state2, 3);
    pulseArm(1);
    checkOutput("dut2_arm_in_holdoff", state2, 3);
    for (int i = 0; i < 15; i++) applyStimulus(1, 0, 1'b0, 3);
    checkOutput("dut2_still_holdoff", state2, 3);
    applyStimulus(1, 0, 1'b0, 3);
    checkOutput("dut2_idle", state2, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1000, 1'b0, 3);
    checkOutput("dut2_idle_no_onset", state2, 0);
    checkOutput("dut2_energy", energy2, 10000);
    pulseArm(1);
    checkOutput("dut2_rearmed", state2, 1);
    pulseArm(1);
    checkOutput("dut2_arm_in_armed", state2, 1);
    applyStimulus(1, 1000, 1'b1, 3);
    checkOutput("dut2_rearm_onset_ts", ts2, 36);
    checkOutput("dut2_after_onset_state", state2, 3);

    idle(5);
    checkOutput("energy_queue_drained", energyQ.size(), 0);
    checkOutput("onset_queue_drained", onsetQ.size(), 0);
    checkOutput("onset2_queue_drained", onset2Q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/fir_onset_detector.md
Name: fir_onset_detector

Overview:
- Sits directly downstream of the channel FIR stage and consumes its filtered sample stream (one sample per FIR output-valid strobe).
- Computes a sliding-window magnitude energy over the last 2^WIN_LOG2 samples.
- Detects acoustic onsets with threshold hysteresis and a holdoff period.
- Latches a sample-count timestamp per onset, so per-channel onset times can be compared for source localisation.

Parameters:
- DW, 23: filtered sample width, two's complement, matches FIR output width.
- WIN_LOG2, 4: log2 of window length; WIN = 16 samples.
- TS_W, 24: timestamp counter width.
- HOLDOFF, 400: samples to ignore after an onset before re-evaluation.
- AUTO_REARM, 1: 1 = return to ARMED after holdoff; 0 = return to IDLE.

Ports:
- clk_clk, input, 1: system clock (50 MHz domain).
- reset_n, input, 1: reset; asynchronous, active-high (asserted = 1).
- sample_in, input, DW: signed filtered sample.
- sample_valid, input, 1: single-cycle strobe; sample_in is valid this cycle.
- arm, input, 1: pulse; IDLE to ARMED.
- thresh_on, input, DW+WIN_LOG2: onset threshold, unsigned.
- thresh_off, input, DW+WIN_LOG2: release threshold, unsigned.
- energy_out, output, DW+WIN_LOG2: current window sum, unsigned.
- onset, output, 1: single-cycle onset pulse.
- onset_ts, output, TS_W: timestamp of the triggering sample.
- ts_valid, output, 1: onset_ts holds a captured value.
- state_out, output, 2: 0 IDLE, 1 ARMED, 2 TRIGGERED, 3 HOLDOFF.

Behaviour:
- Reset values: all outputs 0, ring buffer all zeros, sample counter 0, state IDLE, holdoff counter 0.
- Magnitude: mag = |sample_in|. The most negative input -2^(DW-1) saturates to 2^(DW-1)-1. mag width is DW-1.
- Ring buffer:
  - WIN entries of mag, written at a write pointer that advances mod WIN on each sample_valid.
  - On sample_valid: sum <= sum + mag_new - buffer[wptr]; buffer[wptr] <= mag_new.
  - The sum never overflows (width DW+WIN_LOG2). Zero-initialised entries make partial-window sums exact.
- energy_out updates 1 cycle after sample_valid. It holds between strobes.
- Sample counter:
  - The first sample after reset has timestamp 0.
  - Counter increments on each sample_valid and wraps 2^TS_W-1 to 0.
  - The timestamp of each sample is registered alongside energy_out (ts_e).
- FSM evaluates energy_out in the cycle after it updates (flag upd = delayed sample_valid).
  - IDLE: arm=1 to ARMED. All other inputs ignored.
  - ARMED: upd && energy_out >= thresh_on to TRIGGERED; onset_ts <= ts_e; ts_valid <= 1.
  - TRIGGERED: lasts exactly 1 cycle; onset=1 only in this cycle. Load holdoff counter with HOLDOFF. Go to HOLDOFF.
  - HOLDOFF: decrement the counter on each sample_valid (saturate at 0). When counter==0 && upd && energy_out < thresh_off, go to ARMED (AUTO_REARM=1) or IDLE (AUTO_REARM=0).
- Onset latency: onset asserts 2 cycles after the sample_valid that carries the crossing sample.
- arm is ignored outside IDLE.
- The datapath keeps processing samples in every state, including TRIGGERED.
- onset_ts and ts_valid hold until the next onset or reset. A new onset overwrites onset_ts.
- thresh_off > thresh_on is legal. Release then happens as soon as the holdoff expires and energy is below thresh_off.
- Thresholds are sampled live each evaluation; no latching.
- Back-to-back sample_valid on consecutive cycles must be supported with full throughput.
- reset_n assertion mid-operation clears all state immediately (asynchronous), including the ring buffer and timestamp. No pending onset survives.

Test Plan:
- Reset, arm, then 16 samples of +1000 with thresh_on=10000 → energy_out steps 1000…16000; onset fires after the 10th sample (energy 10000), onset_ts=9, ts_valid=1, state 2 then 3.
- Same window with mixed samples -1000/+1000 → identical energies to the previous case (magnitude check). Input -4194304 → mag 4194303, no wrap.
- After onset, HOLDOFF=400, feed 1000 samples of 0 with thresh_off=500 → state returns to ARMED when the 400th post-onset sample is processed; a second burst of +1000 triggers onset again with its correct timestamp.
- Energy held above thresh_off for 600 zero-free samples → remains in HOLDOFF past counter expiry, exits on the first evaluation with energy < thresh_off.
- AUTO_REARM=0 → after holdoff, state IDLE; further bursts produce no onset until an arm pulse; arm pulses during ARMED/HOLDOFF cause no state change.
- Assert reset_n for 1 cycle mid-burst (energy 8000) → energy_out=0, state IDLE, ts_valid=0 immediately; after re-arm, the first sample has timestamp 0.
